wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master_pkg.sv | 24 ++
 rtl/wb_cmd_master_timeout_cnt.sv | 38 +++
 rtl/wb_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;
  localparam int unsigned TO_CNT_W = 16;

  localparam logic [TO_CNT_W-1:0] TIMEOUT_CYCLES_DEF = 16'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Latched command payload presented on the bus for the whole BUS state.
  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_cmd_master_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles from a clear, flags when LIMIT is reached.
module wb_timeout_cnt
  import wb_cmd_master_pkg::*;
#(
  parameter logic [TO_CNT_W-1:0] LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;

  assign expired_c = (cnt_q == LIMIT);

  // Next count: clear wins, otherwise advance until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired_c) begin
      cnt_d = cnt_q + TO_CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone master with registered outputs.
// Optional bus timeout compiled in with WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter logic [TO_CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [WB_SEL_W-1:0] SEL_DEFAULT    = 4'hF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_addr,
  input  logic [WB_DAT_W-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic                wb_ack_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i
);

  state_e              state_q,     state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cyc_q,       cyc_d;
  logic                stb_q,       stb_d;
  logic [WB_SEL_W-1:0] sel_q,       sel_d;
  wb_req_t             req_q,       req_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                expired_c;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;

  // Counter is held at zero outside BUS so every bus phase starts from zero.
  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clear     (state_q != ST_BUS),
    .enable    ((state_q == ST_BUS) && !wb_ack_i),
    .expired_c (expired_c)
  );

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout;

  // Without the timeout the bus phase only ends on ack.
  assign expired_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign rsp_err        = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = req_q.we;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = req_q.adr;
  assign wb_dat_o  = req_q.dat;

  // Next-state and next-output logic for IDLE -> BUS -> RESP.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    sel_d       = sel_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          sel_d       = SEL_DEFAULT;
          req_d.we    = cmd_we;
          req_d.adr   = cmd_addr;
          req_d.dat   = cmd_wdata;
        end
      end

      ST_BUS: begin
        // Ack takes priority over a timeout on the same edge.
        if (wb_ack_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          req_d.we    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_q.we ? '0 : wb_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else if (expired_c) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          req_d.we    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b1;
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      sel_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      sel_q       <= sel_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT_CYCLES = 8).
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  int checks   = 0;
  int failures = 0;
  int hi;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .TIMEOUT_CYCLES (16'd8),
    .SEL_DEFAULT    (4'hF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one command for a single cycle; returns on the negedge after acceptance.
  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Responder: acks at the ack_at-th stb cycle (0 = zero-wait, -1 = never); counts stb-high cycles.
  task automatic bus_phase(input int ack_at, input int max_cyc, input logic [31:0] rd,
                           input logic exp_we, input logic [31:0] exp_adr,
                           input logic [31:0] exp_dat, output int n_hi);
    n_hi = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!wb_stb_o) break;
      n_hi++;
      chk("bus_cyc", wb_cyc_o, 1);
      chk("bus_we", wb_we_o, exp_we);
      chk("bus_adr", wb_adr_o, exp_adr);
      chk("bus_dat", wb_dat_o, exp_dat);
      chk("bus_sel", wb_sel_o, 4'hF);
      chk("bus_cmd_ready", cmd_ready, 0);
      wb_ack_i = (i == ack_at);
      wb_dat_i = rd;
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
  endtask

  // Check the response, hold it under backpressure with a competing command, then consume it.
  task automatic resp_phase(input logic [31:0] exp_rd, input logic exp_err, input int hold);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_cyc_low", wb_cyc_o, 0);
    chk("rsp_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = 32'h4444_0000;
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_err", rsp_err, exp_err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_cyc", wb_cyc_o, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_no_cyc", wb_cyc_o, 0);
  endtask

  // Reset while a transfer is in flight must leave no response behind.
  task automatic reset_abort();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_rsp_valid", rsp_valid, 0);
    chk("rel_cyc", wb_cyc_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    wb_ack_i  = 1'b0;
    wb_dat_i  = '0;

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_cyc", wb_cyc_o, 0);
    chk("reset_stb", wb_stb_o, 0);
    chk("reset_we", wb_we_o, 0);
    chk("reset_sel", wb_sel_o, 0);
    chk("reset_adr", wb_adr_o, 0);
    chk("reset_dat", wb_dat_o, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_cmd_ready", cmd_ready, 1);

    // Stray ack while idle.
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hBAD0_BAD0;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("idle_ack_rsp_valid", rsp_valid, 0);
    chk("idle_ack_cyc", wb_cyc_o, 0);
    chk("idle_ack_cmd_ready", cmd_ready, 1);

    // Write, ack one cycle after stb: stb high for 2 cycles.
    send_cmd(1'b1, 32'h2000_0008, 32'hFFFF_FFFF);
    bus_phase(1, 50, 32'hDEAD_BEEF, 1'b1, 32'h2000_0008, 32'hFFFF_FFFF, hi);
    chk("write_stb_cycles", hi, 2);
    resp_phase(32'h0, 1'b0, 0);

    // Read-back, zero-wait ack, then 5 cycles of backpressure.
    send_cmd(1'b0, 32'h2000_0008, 32'h1111_2222);
    bus_phase(0, 50, 32'hFFFF_FFFF, 1'b0, 32'h2000_0008, 32'h1111_2222, hi);
    chk("read_stb_cycles", hi, 1);
    resp_phase(32'hFFFF_FFFF, 1'b0, 5);

    // Read with three wait states.
    send_cmd(1'b0, 32'h0000_0FFC, 32'h0);
    bus_phase(3, 50, 32'hA5A5_0F0F, 1'b0, 32'h0000_0FFC, 32'h0, hi);
    chk("wait3_stb_cycles", hi, 4);
    resp_phase(32'hA5A5_0F0F, 1'b0, 1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // No ack: counter 0..8 gives 9 stb cycles, then an error response.
    send_cmd(1'b0, 32'h1000_0000, 32'h0);
    bus_phase(-1, 50, 32'h7777_7777, 1'b0, 32'h1000_0000, 32'h0, hi);
    chk("timeout_stb_cycles", hi, 9);
    resp_phase(32'h0, 1'b1, 0);

    // Ack on the edge where the counter hits the limit: ack wins.
    send_cmd(1'b0, 32'h1000_0004, 32'h0);
    bus_phase(8, 50, 32'h5A5A_1234, 1'b0, 32'h1000_0004, 32'h0, hi);
    chk("ack_at_limit_stb_cycles", hi, 9);
    resp_phase(32'h5A5A_1234, 1'b0, 0);
`else
    // No timeout: stb stays up for 1000 cycles with no response.
    send_cmd(1'b0, 32'h1000_0000, 32'h0);
    bus_phase(-1, 1000, 32'h7777_7777, 1'b0, 32'h1000_0000, 32'h0, hi);
    chk("no_timeout_stb_cycles", hi, 1000);
    chk("no_timeout_stb_still_high", wb_stb_o, 1);
    chk("no_timeout_no_rsp", rsp_valid, 0);
    reset_abort();
`endif

    // Reset on the third bus cycle, then a normal command.
    send_cmd(1'b0, 32'h3000_0010, 32'h0);
    bus_phase(-1, 2, 32'h0, 1'b0, 32'h3000_0010, 32'h0, hi);
    chk("pre_reset_stb_cycles", hi, 2);
    chk("third_cycle_stb", wb_stb_o, 1);
    reset_abort();
    repeat (3) begin
      @(negedge clk);
      chk("after_abort_no_rsp", rsp_valid, 0);
    end
    send_cmd(1'b0, 32'h3000_0010, 32'h0);
    bus_phase(0, 50, 32'h0BAD_F00D, 1'b0, 32'h3000_0010, 32'h0, hi);
    chk("recover_stb_cycles", hi, 1);
    resp_phase(32'h0BAD_F00D, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
